// File: rtl/jtframe_ioctl_pkg.sv
// ============================================================================
//  Module      : jtframe_ioctl_pkg
//  Description : data_io file-transfer command codes and receiver FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package jtframe_ioctl_pkg;

    localparam logic [7:0] UIO_FILE_TX     = 8'h53;
    localparam logic [7:0] UIO_FILE_TX_DAT = 8'h54;
    localparam logic [7:0] UIO_FILE_INDEX  = 8'h55;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CMD     = 3'd1,
        FTX_ARG = 3'd2,
        IDX_ARG = 3'd3,
        DATA    = 3'd4,
        IGNORE  = 3'd5
    } ioctl_state_e;

endpackage

`default_nettype wire

// File: rtl/jtframe_spi_byte_rx.sv
// ============================================================================
//  Module      : jtframe_spi_byte_rx
//  Description : SPI pin synchronizers, SCK rising-edge detect and byte framing.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jtframe_spi_byte_rx (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_sck,
    input  logic       spi_di,
    input  logic       spi_ss,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       ss_active
);

    logic       sck_meta_q, sck_meta_d, sck_sync_q, sck_sync_d, sck_prev_q, sck_prev_d;
    logic       di_meta_q,  di_meta_d,  di_sync_q,  di_sync_d;
    logic       ss_meta_q,  ss_meta_d,  ss_sync_q,  ss_sync_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       sck_rise;

    always_comb begin
        sck_meta_d = spi_sck;
        sck_sync_d = sck_meta_q;
        sck_prev_d = sck_sync_q;
        di_meta_d  = spi_di;
        di_sync_d  = di_meta_q;
        ss_meta_d  = spi_ss;
        ss_sync_d  = ss_meta_q;

        sck_rise   = sck_sync_q & ~sck_prev_q;
        ss_active  = ~ss_sync_q;
        rx_byte    = {shift_q[6:0], di_sync_q};
        // The counter only reaches 7 while the frame was open, so a bit-8 edge
        // arriving together with SS2 release still completes its byte.
        byte_valid = sck_rise && (cnt_q == 3'd7);

        cnt_d      = cnt_q;
        shift_d    = shift_q;
        if (!ss_active) begin
            cnt_d = 3'd0;
        end else if (sck_rise) begin
            cnt_d   = cnt_q + 3'd1;
            shift_d = rx_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sck_meta_q <= 1'b0;
            sck_sync_q <= 1'b0;
            sck_prev_q <= 1'b0;
            di_meta_q  <= 1'b0;
            di_sync_q  <= 1'b0;
            ss_meta_q  <= 1'b1;
            ss_sync_q  <= 1'b1;
            cnt_q      <= 3'd0;
            shift_q    <= 8'd0;
        end else begin
            sck_meta_q <= sck_meta_d;
            sck_sync_q <= sck_sync_d;
            sck_prev_q <= sck_prev_d;
            di_meta_q  <= di_meta_d;
            di_sync_q  <= di_sync_d;
            ss_meta_q  <= ss_meta_d;
            ss_sync_q  <= ss_sync_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/jtframe_ioctl_rx.sv
// ============================================================================
//  Module      : jtframe_ioctl_rx
//  Description : data_io SPI download receiver producing the ioctl write stream.
//                JTFRAME_IOCTL_SUM_EN enables the 16-bit running byte sum.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jtframe_ioctl_rx
    import jtframe_ioctl_pkg::*;
#(
    parameter int AW = 22
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          SPI_SCK,
    input  logic          SPI_DI,
    input  logic          SPI_SS2,
    output logic          downloading,
    output logic [7:0]    ioctl_index,
    output logic [AW-1:0] ioctl_addr,
    output logic [7:0]    ioctl_data,
    output logic          ioctl_wr,
    output logic [15:0]   ioctl_sum
);

    logic [7:0]   rx_byte;
    logic         byte_valid;
    logic         ss_active;

    ioctl_state_e state_q, state_d;
    logic         dl_q, dl_d;
    logic [7:0]   index_q, index_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]   data_q, data_d;
    logic         wr_q, wr_d;
    logic         dl_start;

    jtframe_spi_byte_rx u_byte_rx (
        .clk        (clk),
        .rst        (rst),
        .spi_sck    (SPI_SCK),
        .spi_di     (SPI_DI),
        .spi_ss     (SPI_SS2),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .ss_active  (ss_active)
    );

    // Only a fresh start of a transfer rewinds the address and the sum.
    assign dl_start = (state_q == FTX_ARG) && byte_valid && (rx_byte != 8'd0) && !dl_q;

    always_comb begin
        state_d = state_q;
        dl_d    = dl_q;
        index_d = index_q;
        data_d  = data_q;
        wr_d    = 1'b0;
        addr_d  = wr_q ? addr_q + {{(AW-1){1'b0}}, 1'b1} : addr_q;
        if (dl_start) begin
            addr_d = '0;
        end

        case (state_q)
            IDLE: begin
                if (ss_active) state_d = CMD;
            end
            CMD: begin
                if (byte_valid) begin
                    case (rx_byte)
                        UIO_FILE_TX:     state_d = FTX_ARG;
                        UIO_FILE_TX_DAT: state_d = DATA;
                        UIO_FILE_INDEX:  state_d = IDX_ARG;
                        default:         state_d = IGNORE;
                    endcase
                end
            end
            FTX_ARG: begin
                if (byte_valid) begin
                    dl_d    = (rx_byte != 8'd0);
                    state_d = IGNORE;
                end
            end
            IDX_ARG: begin
                if (byte_valid) begin
                    index_d = rx_byte;
                    state_d = IGNORE;
                end
            end
            DATA: begin
                if (byte_valid && dl_q) begin
                    wr_d   = 1'b1;
                    data_d = rx_byte;
                end
            end
            IGNORE: ;
            default: state_d = IDLE;
        endcase

        // A byte completed in the same cycle as SS2 release is handled above first.
        if (!ss_active) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            dl_q    <= 1'b0;
            index_q <= 8'd0;
            addr_q  <= '0;
            data_q  <= 8'd0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            dl_q    <= dl_d;
            index_q <= index_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
        end
    end

`ifdef JTFRAME_IOCTL_SUM_EN
    logic [15:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (dl_start) begin
            sum_d = 16'd0;
        end else if (wr_q) begin
            sum_d = sum_q + {8'd0, data_q};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= 16'd0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign ioctl_sum = sum_q;
`else
    assign ioctl_sum = 16'd0;
`endif

    assign downloading = dl_q;
    assign ioctl_index = index_q;
    assign ioctl_addr  = addr_q;
    assign ioctl_data  = data_q;
    assign ioctl_wr    = wr_q;

endmodule

`default_nettype wire

// File: tb/tb_jtframe_ioctl_rx.sv
// ============================================================================
//  Module      : tb_jtframe_ioctl_rx
//  Description : Self-checking bench: SPI host driver, frame-level model, checker.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_jtframe_ioctl_rx;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic SPI_SCK = 1'b0;
    logic SPI_DI = 1'b0;
    logic SPI_SS2 = 1'b1;

    always #5 clk = ~clk;

    logic        d22_dl, d4_dl, d22_wr, d4_wr;
    logic [7:0]  d22_idx, d4_idx, d22_data, d4_data;
    logic [21:0] d22_addr;
    logic [3:0]  d4_addr;
    logic [15:0] d22_sum, d4_sum;

    jtframe_ioctl_rx #(.AW(22)) u_dut22 (
        .clk(clk), .rst(rst), .SPI_SCK(SPI_SCK), .SPI_DI(SPI_DI), .SPI_SS2(SPI_SS2),
        .downloading(d22_dl), .ioctl_index(d22_idx), .ioctl_addr(d22_addr),
        .ioctl_data(d22_data), .ioctl_wr(d22_wr), .ioctl_sum(d22_sum)
    );

    jtframe_ioctl_rx #(.AW(4)) u_dut4 (
        .clk(clk), .rst(rst), .SPI_SCK(SPI_SCK), .SPI_DI(SPI_DI), .SPI_SS2(SPI_SS2),
        .downloading(d4_dl), .ioctl_index(d4_idx), .ioctl_addr(d4_addr),
        .ioctl_data(d4_data), .ioctl_wr(d4_wr), .ioctl_sum(d4_sum)
    );

    // Frame-level model state
    logic        m_dl = 1'b0;
    logic [7:0]  m_idx = 8'd0;
    logic [7:0]  m_data = 8'd0;
    logic [21:0] m_addr = 22'd0;
    logic [15:0] m_sum = 16'd0;

    // Expected write stream (stimulus appends, checker consumes)
    logic [21:0] exp_addr [0:4095];
    logic [7:0]  exp_data [0:4095];
    int          exp_wr = 0;
    int          exp_rd = 0;

    // Model pins (stimulus posts, checker compares)
    string       pin_nm  [0:63];
    logic [31:0] pin_act [0:63];
    logic [31:0] pin_exp [0:63];
    int          pin_wr = 0;
    int          pin_rd = 0;

    int          ckpt_req = 0;
    int          ckpt_ack = 0;
    time         last_rise = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    bit          prev_wr = 1'b0;

    logic [7:0]  tx_q [$];

    function automatic void model_frame();
        int n = tx_q.size();
        if (n == 0) return;
        case (tx_q[0])
            8'h53: if (n >= 2) begin
                if (tx_q[1] != 8'd0 && !m_dl) begin
                    m_addr = 22'd0;
                    m_sum  = 16'd0;
                end
                m_dl = (tx_q[1] != 8'd0);
            end
            8'h54: for (int i = 1; i < n; i++) begin
                if (m_dl) begin
                    exp_addr[exp_wr] = m_addr;
                    exp_data[exp_wr] = tx_q[i];
                    exp_wr++;
                    m_addr = m_addr + 22'd1;
                    m_sum  = m_sum + {8'd0, tx_q[i]};
                    m_data = tx_q[i];
                end
            end
            8'h55: if (n >= 2) m_idx = tx_q[1];
            default: ;
        endcase
    endfunction

    function automatic void model_reset();
        m_dl = 1'b0; m_idx = 8'd0; m_data = 8'd0; m_addr = 22'd0; m_sum = 16'd0;
    endfunction

    function automatic void pin(input string nm, input logic [31:0] act, input logic [31:0] exp);
        pin_nm[pin_wr]  = nm;
        pin_act[pin_wr] = act;
        pin_exp[pin_wr] = exp;
        pin_wr++;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic send_bits(input logic [7:0] b, input int n, input bit ss_same);
        for (int i = 7; i >= 8 - n; i--) begin
            int h;
            h = int'($urandom_range(20, 30));
            SPI_DI = b[i];
            #(h);
            SPI_SCK = 1'b1;
            if (i == 0) begin
                last_rise = $time;
                if (ss_same) SPI_SS2 = 1'b1;
            end
            #(h);
            SPI_SCK = 1'b0;
        end
    endtask

    task automatic checkpoint();
        ckpt_req++;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            if (ckpt_ack == ckpt_req) break;
        end
        if (ckpt_ack != ckpt_req) begin
            $display("FAIL checkpoint_timeout: got ack %0d, expected %0d", ckpt_ack, ckpt_req);
            $fatal(1, "checker stalled");
        end
    endtask

    task automatic send_frame(input int partial, input bit ss_same);
        int last;
        model_frame();
        last = tx_q.size() - 1;
        SPI_SS2 = 1'b0;
        #30;
        for (int k = 0; k <= last; k++) begin
            send_bits(tx_q[k], 8, ss_same && (k == last) && (partial == 0));
        end
        if (partial > 0) send_bits(8'($urandom), partial, 1'b0);
        #25;
        SPI_SS2 = 1'b1;
        repeat (8) @(posedge clk);
        checkpoint();
    endtask

    // Checker: the only process that steps the comparison counters
    initial begin
        forever begin
            @(negedge clk);
            while (pin_rd < pin_wr) begin
                chk(pin_nm[pin_rd], pin_act[pin_rd], pin_exp[pin_rd]);
                pin_rd++;
            end
            if (rst) begin
                prev_wr = 1'b0;
            end else begin
                if (d22_wr || d4_wr) begin
                    chk("wr_both_widths", {31'd0, d4_wr}, {31'd0, d22_wr});
                    chk("wr_not_back_to_back", {31'd0, prev_wr}, 32'd0);
                    if (exp_rd >= exp_wr) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_wr: got write of 0x%0h at 0x%0h, expected none",
                                 d22_data, d22_addr);
                    end else begin
                        time dt;
                        dt = $time - last_rise;
                        chk("wr_addr", {10'd0, d22_addr}, {10'd0, exp_addr[exp_rd]});
                        chk("wr_addr_aw4", {28'd0, d4_addr}, {28'd0, exp_addr[exp_rd][3:0]});
                        chk("wr_data", {24'd0, d22_data}, {24'd0, exp_data[exp_rd]});
                        chk("wr_data_aw4", {24'd0, d4_data}, {24'd0, exp_data[exp_rd]});
                        n_cmp++;
                        if (dt < 20 || dt > 40) begin
                            n_err++;
                            $display("FAIL wr_latency: got %0t after bit-8 edge, expected 20..40 ns", dt);
                        end
                        exp_rd++;
                    end
                end
                prev_wr = d22_wr;
                if (ckpt_ack != ckpt_req) begin
                    chk("missing_wr", exp_rd, exp_wr);
                    exp_rd = exp_wr;
                    chk("ckpt_wr_idle", {31'd0, d22_wr}, 32'd0);
                    chk("ckpt_downloading", {31'd0, d22_dl}, {31'd0, m_dl});
                    chk("ckpt_downloading_aw4", {31'd0, d4_dl}, {31'd0, m_dl});
                    chk("ckpt_index", {24'd0, d22_idx}, {24'd0, m_idx});
                    chk("ckpt_addr", {10'd0, d22_addr}, {10'd0, m_addr});
                    chk("ckpt_addr_aw4", {28'd0, d4_addr}, {28'd0, m_addr[3:0]});
                    chk("ckpt_data", {24'd0, d22_data}, {24'd0, m_data});
`ifdef JTFRAME_IOCTL_SUM_EN
                    chk("ckpt_sum", {16'd0, d22_sum}, {16'd0, m_sum});
                    chk("ckpt_sum_aw4", {16'd0, d4_sum}, {16'd0, m_sum});
`else
                    chk("ckpt_sum", {16'd0, d22_sum}, 32'd0);
                    chk("ckpt_sum_aw4", {16'd0, d4_sum}, 32'd0);
`endif
                    ckpt_ack = ckpt_req;
                end
            end
        end
    end

    initial begin
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        checkpoint();

        tx_q = '{8'h54, 8'h11, 8'h22};
        send_frame(0, 1'b0);
        pin("nodl_addr", {10'd0, m_addr}, 32'd0);
        pin("nodl_writes", exp_wr, 32'd0);

        tx_q = '{8'h53, 8'h01};             send_frame(0, 1'b0);
        tx_q = '{8'h54, 8'hAA, 8'hBB, 8'hCC}; send_frame(0, 1'b0);
        tx_q = '{8'h53, 8'h00};             send_frame(0, 1'b0);
        pin("basic_addr", {10'd0, m_addr}, 32'd3);
        pin("basic_dl", {31'd0, m_dl}, 32'd0);
        pin("basic_data", {24'd0, m_data}, 32'hCC);
        pin("basic_sum", {16'd0, m_sum}, 32'h0231);
        pin("basic_wr1_addr", {10'd0, exp_addr[1]}, 32'd1);

        tx_q = '{8'h55, 8'h07};
        send_frame(0, 1'b0);
        pin("index", {24'd0, m_idx}, 32'h07);
        pin("index_dl", {31'd0, m_dl}, 32'd0);

        tx_q = '{8'h53, 8'h01};             send_frame(0, 1'b0);
        tx_q = '{8'h99, 8'h54, 8'h12};      send_frame(0, 1'b0);
        pin("ignore_writes", exp_wr, 32'd3);
        pin("ignore_addr", {10'd0, m_addr}, 32'd0);

        tx_q = '{8'h54};                    send_frame(5, 1'b0);
        tx_q = '{8'h54, 8'h5A};             send_frame(0, 1'b0);
        pin("partial_addr", {10'd0, exp_addr[3]}, 32'd0);
        pin("partial_data", {24'd0, exp_data[3]}, 32'h5A);

        tx_q = '{8'h54, 8'h3C};             send_frame(0, 1'b1);
        pin("ss_same_addr", {10'd0, m_addr}, 32'd2);

        tx_q = '{8'h53, 8'h01};             send_frame(0, 1'b0);
        pin("restart_no_clear", {10'd0, m_addr}, 32'd2);

        tx_q = '{8'h53, 8'h00};             send_frame(0, 1'b0);
        tx_q = '{8'h53, 8'h01};             send_frame(0, 1'b0);
        tx_q = '{8'h54};
        for (int k = 0; k < 17; k++) tx_q.push_back(8'($urandom));
        send_frame(0, 1'b0);
        pin("wrap_addr", {10'd0, m_addr}, 32'd17);
        pin("wrap_17th_aw4", {28'd0, exp_addr[exp_wr-1][3:0]}, 32'd0);

        tx_q = '{8'h54, 8'hA1, 8'hB2};
        model_frame();
        SPI_SS2 = 1'b0;
        #30;
        for (int k = 0; k < 3; k++) send_bits(tx_q[k], 8, 1'b0);
        repeat (6) @(posedge clk);
        rst = 1'b1;
        model_reset();
        SPI_SS2 = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        checkpoint();
        tx_q = '{8'h53, 8'h01};             send_frame(0, 1'b0);
        tx_q = '{8'h54, 8'h77};             send_frame(0, 1'b0);
        pin("post_rst_addr", {10'd0, exp_addr[exp_wr-1]}, 32'd0);
        pin("post_rst_data", {24'd0, exp_data[exp_wr-1]}, 32'h77);

        for (int f = 0; f < 100; f++) begin
            logic [7:0] cmd, arg;
            int r, nextra, partial;
            bit ss_same;
            r = int'($urandom_range(0, 9));
            cmd = (r <= 2) ? 8'h53 : (r <= 6) ? 8'h54 : (r == 7) ? 8'h55 : 8'($urandom);
            tx_q.delete();
            tx_q.push_back(cmd);
            nextra = (cmd == 8'h54) ? int'($urandom_range(0, 6)) : int'($urandom_range(0, 2));
            for (int k = 0; k < nextra; k++) begin
                arg = 8'($urandom);
                if (cmd == 8'h53 && k == 0 && $urandom_range(0, 2) == 0) arg = 8'h00;
                tx_q.push_back(arg);
            end
            partial = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
            ss_same = (partial == 0) && ($urandom_range(0, 4) == 0);
            send_frame(partial, ss_same);
        end

        repeat (4) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
